// File: rtl/el2_btb_wr_sched_if.sv
// el2_btb_wr_sched_if: request, write-port and status signals of the BTB write scheduler
interface el2_btb_wr_sched_if #(parameter int IDX_W = 8, parameter int DATA_W = 32);
    logic              flush_req;
    logic              flush_busy;
    logic              exu_upd_valid;
    logic [IDX_W-1:0]  exu_upd_index;
    logic [DATA_W-1:0] exu_upd_data;
    logic              dec_upd_valid;
    logic              dec_upd_ready;
    logic [IDX_W-1:0]  dec_upd_index;
    logic [DATA_W-1:0] dec_upd_data;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_index;
    logic [DATA_W-1:0] wr_data;
    logic              wr_inval;
    logic              drop_evt;
    modport master (
        output flush_req, exu_upd_valid, exu_upd_index, exu_upd_data,
               dec_upd_valid, dec_upd_index, dec_upd_data,
        input  flush_busy, dec_upd_ready, wr_en, wr_index, wr_data, wr_inval, drop_evt
    );
    modport slave (
        input  flush_req, exu_upd_valid, exu_upd_index, exu_upd_data,
               dec_upd_valid, dec_upd_index, dec_upd_data,
        output flush_busy, dec_upd_ready, wr_en, wr_index, wr_data, wr_inval, drop_evt
    );
endinterface

// File: rtl/el2_btb_wr_sched.sv
// el2_btb_wr_sched: BTB/BHT write-port scheduler with invalidation sweep, EXU priority
// and a one-entry skid buffer for decode corrections.
module el2_btb_wr_sched #(
    parameter int BTB_ADDR_HI = 9,
    parameter int BTB_ADDR_LO = 2,
    parameter int DATA_W      = 32,
    localparam int IDX_W      = BTB_ADDR_HI - BTB_ADDR_LO + 1
) (
    input logic clk,
    input logic rst_l,
    el2_btb_wr_sched_if.slave u
);
    typedef enum logic {SWEEP, RUN} state_t;
    state_t st, st_n;
    logic [IDX_W-1:0]  cnt, cnt_n, ski, ski_n, wi_n;
    logic [DATA_W-1:0] skd, skd_n, wd_n;
    logic skv, skv_n, we_n, inv_n, drop_n, busy_n, rdy_n, dec_acc;
    always_comb begin
        st_n    = st;
        cnt_n   = cnt;
        skv_n   = skv;
        ski_n   = ski;
        skd_n   = skd;
        we_n    = 1'b0;
        wi_n    = u.wr_index;
        wd_n    = u.wr_data;
        inv_n   = 1'b0;
        drop_n  = 1'b0;
        dec_acc = u.dec_upd_valid & u.dec_upd_ready;
        if (st == SWEEP) begin
            drop_n = u.exu_upd_valid;
            if (u.flush_req) cnt_n = '0;
            else begin
                we_n  = 1'b1;
                wi_n  = cnt;
                wd_n  = '0;
                inv_n = 1'b1;
                cnt_n = cnt + 1'b1;
                st_n  = &cnt ? RUN : SWEEP;
            end
        end else if (u.flush_req) begin
            st_n   = SWEEP;
            cnt_n  = '0;
            skv_n  = 1'b0;
            drop_n = u.exu_upd_valid | dec_acc | skv;
        end else if (u.exu_upd_valid) begin
            we_n = 1'b1;
            wi_n = u.exu_upd_index;
            wd_n = u.exu_upd_data;
            // EXU data is newer than a pending correction to the same entry
            if (skv && ski == u.exu_upd_index) begin
                skv_n  = 1'b0;
                drop_n = 1'b1;
            end
            if (dec_acc) begin
                skv_n = 1'b1;
                ski_n = u.dec_upd_index;
                skd_n = u.dec_upd_data;
            end
        end else if (skv) begin
            we_n  = 1'b1;
            wi_n  = ski;
            wd_n  = skd;
            skv_n = 1'b0;
        end else if (dec_acc) begin
            we_n = 1'b1;
            wi_n = u.dec_upd_index;
            wd_n = u.dec_upd_data;
        end
        busy_n = st_n == SWEEP;
        // ready only when the skid will be empty, so an accept can never hit a full skid
        rdy_n  = st == RUN && st_n == RUN && !skv_n;
    end
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            st              <= SWEEP;
            cnt             <= '0;
            skv             <= 1'b0;
            ski             <= '0;
            skd             <= '0;
            u.flush_busy    <= 1'b1;
            u.dec_upd_ready <= 1'b0;
            u.wr_en         <= 1'b0;
            u.wr_index      <= '0;
            u.wr_data       <= '0;
            u.wr_inval      <= 1'b0;
            u.drop_evt      <= 1'b0;
        end else begin
            st              <= st_n;
            cnt             <= cnt_n;
            skv             <= skv_n;
            ski             <= ski_n;
            skd             <= skd_n;
            u.flush_busy    <= busy_n;
            u.dec_upd_ready <= rdy_n;
            u.wr_en         <= we_n;
            u.wr_index      <= wi_n;
            u.wr_data       <= wd_n;
            u.wr_inval      <= inv_n;
            u.drop_evt      <= drop_n;
        end
    end
endmodule

// File: tb/tb_el2_btb_wr_sched.sv
// tb_el2_btb_wr_sched: randomized scoreboard bench for the BTB write scheduler
module tb_el2_btb_wr_sched;
    localparam int IDX_W = 8, DATA_W = 32, DEPTH = 256;
    logic clk = 0, rst_l = 0;
    always #5 clk = ~clk;
    el2_btb_wr_sched_if #(.IDX_W(IDX_W), .DATA_W(DATA_W)) bus();
    el2_btb_wr_sched #(.BTB_ADDR_HI(9), .BTB_ADDR_LO(2), .DATA_W(DATA_W)) dut (.clk(clk), .rst_l(rst_l), .u(bus));
    typedef struct {int st; logic [7:0] idx; logic [31:0] data; logic inv;} wr_t;
    typedef struct {int st; logic busy; logic rdy;} fl_t;
    wr_t wq[$];
    fl_t fq[$];
    int  dq[$];
    wr_t skid[$];
    int errors = 0, checks = 0, cyc = 0;
    bit sweeping, rdy;
    int sweep_next;
    logic [7:0]  last_idx;
    logic [31:0] last_data;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask
    // reference: rules applied to the cycle's inputs, results stamped with the cycle they appear
    task automatic model(bit fl, bit ev, logic [7:0] ei, logic [31:0] ed, bit dv, logic [7:0] di, logic [31:0] dd);
        bit acc = dv && rdy;
        bit drop = 0;
        int s = cyc + 1;
        wr_t w;
        if (sweeping) begin
            drop = ev;
            if (fl) sweep_next = 0;
            else begin
                wq.push_back('{s, sweep_next[7:0], 32'h0, 1'b1});
                sweep_next++;
                if (sweep_next == DEPTH) sweeping = 0;
            end
            rdy = 0;
        end else if (fl) begin
            drop = ev || acc || skid.size() > 0;
            skid.delete();
            sweeping = 1;
            sweep_next = 0;
            rdy = 0;
        end else begin
            if (ev) begin
                wq.push_back('{s, ei, ed, 1'b0});
                if (skid.size() > 0 && skid[0].idx == ei) begin
                    drop = 1;
                    skid.delete();
                end
                if (acc) skid.push_back('{0, di, dd, 1'b0});
            end else if (skid.size() > 0) begin
                w = skid.pop_front();
                w.st = s;
                wq.push_back(w);
            end else if (acc) wq.push_back('{s, di, dd, 1'b0});
            rdy = skid.size() == 0;
        end
        fq.push_back('{s, sweeping, rdy});
        if (drop) dq.push_back(s);
    endtask
    task automatic drive(bit fl, bit ev, logic [7:0] ei, logic [31:0] ed, bit dv, logic [7:0] di, logic [31:0] dd);
        bus.flush_req = fl;
        bus.exu_upd_valid = ev;
        bus.exu_upd_index = ei;
        bus.exu_upd_data = ed;
        bus.dec_upd_valid = dv;
        bus.dec_upd_index = di;
        bus.dec_upd_data = dd;
    endtask
    task automatic step(bit fl, bit ev, logic [7:0] ei, logic [31:0] ed, bit dv, logic [7:0] di, logic [31:0] dd);
        @(negedge clk);
        #1;
        drive(fl, ev, ei, ed, dv, di, dd);
        model(fl, ev, ei, ed, dv, di, dd);
    endtask
    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h0, 32'h0, 0, 8'h0, 32'h0);
    endtask
    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_l = 0;
        drive(0, 0, 8'h0, 32'h0, 0, 8'h0, 32'h0);
        sweeping = 1;
        sweep_next = 0;
        rdy = 0;
        skid.delete();
        wq.delete();
        fq.delete();
        dq.delete();
        last_idx = 0;
        last_data = 0;
        #1;
        chk("rst_flush_busy", bus.flush_busy, 1);
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_wr_index", bus.wr_index, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_wr_inval", bus.wr_inval, 0);
        chk("rst_ready", bus.dec_upd_ready, 0);
        chk("rst_drop_evt", bus.drop_evt, 0);
        repeat (2) @(negedge clk);
        #1;
        rst_l = 1;
        model(0, 0, 8'h0, 32'h0, 0, 8'h0, 32'h0);
    endtask
    always @(negedge clk) begin
        fl_t f;
        wr_t w;
        if (rst_l) begin
            if (fq.size() > 0 && fq[0].st == cyc) begin
                f = fq.pop_front();
                chk("flush_busy", bus.flush_busy, f.busy);
                chk("dec_upd_ready", bus.dec_upd_ready, f.rdy);
            end
            if (wq.size() > 0 && wq[0].st < cyc) begin
                w = wq.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_write: index %0h expected at cycle %0d, wr_en low", w.idx, w.st);
            end
            if (bus.wr_en) begin
                if (wq.size() > 0 && wq[0].st == cyc) begin
                    w = wq.pop_front();
                    chk("wr_index", bus.wr_index, w.idx);
                    chk("wr_data", bus.wr_data, w.data);
                    chk("wr_inval", bus.wr_inval, w.inv);
                    last_idx = w.idx;
                    last_data = w.data;
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: index %0h at cycle %0d, no write expected", bus.wr_index, cyc);
                end
            end else begin
                chk("hold_index", bus.wr_index, last_idx);
                chk("hold_data", bus.wr_data, last_data);
            end
            if (dq.size() > 0 && dq[0] < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_drop: drop_evt low, expected high at cycle %0d", dq.pop_front());
            end
            if (bus.drop_evt) begin
                checks++;
                if (dq.size() > 0 && dq[0] == cyc) void'(dq.pop_front());
                else begin
                    errors++;
                    $display("FAIL unexpected_drop: drop_evt high at cycle %0d, expected low", cyc);
                end
            end
        end
    end
    initial begin
        do_reset();
        step(0, 1, 8'h05, 32'h1111, 1, 8'h06, 32'h2222);
        idle(DEPTH + 3);
        step(0, 1, 8'h3A, 32'hDEADBEEF, 0, 8'h0, 32'h0);
        idle(2);
        step(0, 1, 8'h10, 32'hA0A0, 1, 8'h20, 32'hB0B0);
        idle(3);
        step(0, 1, 8'h11, 32'hC1C1, 1, 8'h20, 32'hD2D2);
        step(0, 1, 8'h20, 32'hE3E3, 0, 8'h0, 32'h0);
        idle(3);
        step(0, 1, 8'h12, 32'h1234, 1, 8'h30, 32'h5678);
        step(0, 1, 8'h13, 32'h9ABC, 0, 8'h0, 32'h0);
        idle(2);
        step(1, 0, 8'h0, 32'h0, 0, 8'h0, 32'h0);
        idle(100);
        step(1, 0, 8'h0, 32'h0, 0, 8'h0, 32'h0);
        idle(DEPTH + 3);
        step(0, 1, 8'h40, 32'h4040, 1, 8'h41, 32'h4141);
        step(1, 1, 8'h42, 32'h4242, 0, 8'h0, 32'h0);
        idle(DEPTH + 3);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 499) == 0, $urandom_range(0, 2) == 0, 8'(8'h20 + $urandom_range(0, 3)), $urandom,
                 $urandom_range(0, 1) == 1, 8'(8'h20 + $urandom_range(0, 3)), $urandom);
        idle(DEPTH + 5);
        @(negedge clk);
        #2;
        chk("writes_drained", wq.size(), 0);
        chk("drops_drained", dq.size(), 0);
        do_reset();
        idle(5);
        @(negedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
